// File: rtl/pipe_pkg.sv
// pipe_pkg: shared fetch-stage types and constants
package pipe_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry 32-bit holding register (load, clear, valid); ports clk, rst, i_load, i_clear, i_data -> o_data, o_valid
module fetch_buf
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_valid
);
  logic [31:0] r_data;
  logic        r_valid;
  always_ff @(posedge clk)
    if (rst || i_clear) begin
      r_data  <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: IF stage controller; owns pc, drives imem req/ready, feeds IF/ID (ifidPCin, ifidInstructionIn, ifidWrite, ifFlush) with stall buffering and redirects
module ifetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = pipe_pkg::PC_INC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRdata,
  output logic [31:0] ifidPCin,
  output logic [31:0] ifidInstructionIn,
  output logic        ifidWrite,
  output logic        ifFlush
);
  fetch_state_e r_state, w_next_state;
  logic [31:0]  r_pc, r_tgt, w_pc_next, w_buf_data;
  logic         w_buf_load, w_buf_clear, w_buf_valid;
  assign w_pc_next = r_pc + PC_INC;
  always_ff @(posedge clk)
    r_state <= rst ? FETCH : w_next_state;
  // an unfinished request always has to be waited out in DROP, whatever state issued it
  always_comb
    w_next_state = redirect ? ((r_state != HOLD && !imemReady) ? DROP : FETCH) :
                   (r_state == FETCH) ? ((imemReady && stall) ? HOLD : FETCH) :
                   (r_state == HOLD)  ? (stall ? HOLD : FETCH) :
                   (imemReady ? FETCH : DROP);
  always_comb begin
    imemReq           = !rst && r_state != HOLD;
    imemAddr          = imemReq ? r_pc : 32'h0;
    ifidWrite         = !rst && !redirect && !stall &&
                        ((r_state == FETCH && imemReady) || (r_state == HOLD && w_buf_valid));
    ifFlush           = !rst && (redirect || r_state == DROP || (r_state == FETCH && !imemReady && !stall));
    ifidPCin          = ifidWrite ? w_pc_next : 32'h0;
    ifidInstructionIn = ifidWrite ? (r_state == HOLD ? w_buf_data : imemRdata) : NOP_INSTR;
  end
  // a redirect that lands while a response completes (or while holding) takes effect at once
  always_ff @(posedge clk)
    if (rst) begin
      r_pc  <= RESET_PC;
      r_tgt <= RESET_PC;
    end else begin
      r_pc  <= (redirect && (r_state == HOLD || imemReady)) ? redirectTarget :
               (r_state == DROP && imemReady) ? r_tgt :
               ifidWrite ? w_pc_next : r_pc;
      r_tgt <= redirect ? redirectTarget : r_tgt;
    end
  assign w_buf_load  = r_state == FETCH && imemReady && stall && !redirect;
  assign w_buf_clear = r_state == HOLD && (redirect || !stall);
  fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (imemRdata),
    .o_data  (w_buf_data),
    .o_valid (w_buf_valid)
  );
endmodule
